// File: rtl/dtack_delay_pkg.sv
// Shared definitions for the clocked DTACK delay block: FSM encoding,
// default synchroniser depth and the timeout counter width helper.
package dtack_delay_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_WAIT   = 3'd1;
    localparam logic [2:0] ST_COUNT  = 3'd2;
    localparam logic [2:0] ST_ASSERT = 3'd3;
    localparam logic [2:0] ST_ERROR  = 3'd4;

    localparam int DEF_SYNC_STAGES = 2;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Timeout counter is never narrower than 8 bits.
    function automatic int tmo_width(input int timeout);
        int w;
        w = clog2(timeout + 1);
        return (w < 8) ? 8 : w;
    endfunction

endpackage

// File: rtl/dtack_delay_chan.sv
// One AS/DTACK channel: input synchronisers, delay FSM and counters.
// Optional WAIT timeout with BERR is built when DTACK_TIMEOUT_EN is defined.
module dtack_delay_chan
    import dtack_delay_pkg::*;
#(
    parameter int CNT_W       = 4,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
`ifdef DTACK_TIMEOUT_EN
    ,
    parameter int TIMEOUT     = 255
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             as_n,
    input  logic             dtack_n,
    input  logic [CNT_W-1:0] delay,
    input  logic             bypass,
    output logic             out_n,
    output logic             berr_n,
    output logic [2:0]       state_o
);

    logic [SYNC_STAGES-1:0] as_sync_q, as_sync_d;
    logic [SYNC_STAGES-1:0] dtack_sync_q, dtack_sync_d;
    logic                   as_s, dtack_s;
    logic [2:0]             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   out_q, out_d;

`ifdef DTACK_TIMEOUT_EN
    localparam int TMO_W = tmo_width(TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             berr_q, berr_d;
`endif

    always_comb begin
        as_sync_d    = {as_sync_q[SYNC_STAGES-2:0], as_n};
        dtack_sync_d = {dtack_sync_q[SYNC_STAGES-2:0], dtack_n};
    end

    assign as_s    = as_sync_q[SYNC_STAGES-1];
    assign dtack_s = dtack_sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
`ifdef DTACK_TIMEOUT_EN
        tmo_d   = '0;
`endif
        if (bypass || as_s) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                // IDLE with DTACK already low behaves as WAIT in the same cycle.
                ST_IDLE, ST_WAIT: begin
                    if (!dtack_s) begin
                        if (delay == '0) begin
                            state_d = ST_ASSERT;
                            cnt_d   = '0;
                        end else begin
                            state_d = ST_COUNT;
                            cnt_d   = delay;
                        end
                    end else begin
                        state_d = ST_WAIT;
`ifdef DTACK_TIMEOUT_EN
                        if (state_q == ST_WAIT) begin
                            if (tmo_q == TMO_LAST) begin
                                state_d = ST_ERROR;
                            end else begin
                                tmo_d = tmo_q + 1'b1;
                            end
                        end
`endif
                    end
                end
                // DTACK is ignored here: the start was latched on WAIT exit.
                ST_COUNT: begin
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = ST_ASSERT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                ST_ASSERT, ST_ERROR: begin
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
        out_d = bypass ? (as_s | dtack_s) : (state_d != ST_ASSERT);
`ifdef DTACK_TIMEOUT_EN
        berr_d = bypass ? 1'b1 : (state_d != ST_ERROR);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            as_sync_q    <= '1;
            dtack_sync_q <= '1;
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            out_q        <= 1'b1;
        end else begin
            as_sync_q    <= as_sync_d;
            dtack_sync_q <= dtack_sync_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            out_q        <= out_d;
        end
    end

`ifdef DTACK_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_q  <= '0;
            berr_q <= 1'b1;
        end else begin
            tmo_q  <= tmo_d;
            berr_q <= berr_d;
        end
    end

    assign berr_n = berr_q;
`else
    assign berr_n = 1'b1;
`endif

    assign out_n   = out_q;
    assign state_o = state_q;

endmodule

// File: rtl/dtack_delay_sync.sv
// Multi-channel clocked DTACK delay: CHANNELS independent dtack_delay_chan copies.
// Define DTACK_TIMEOUT_EN to build the WAIT timeout / BERR path.
module dtack_delay_sync
    import dtack_delay_pkg::*;
#(
    parameter int CHANNELS    = 2,
    parameter int CNT_W       = 4,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int TIMEOUT     = 255
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic [CHANNELS-1:0]       AS,
    input  logic [CHANNELS-1:0]       DTACK,
    input  logic [CHANNELS*CNT_W-1:0] DELAY,
    input  logic [CHANNELS-1:0]       BYPASS,
    output logic [CHANNELS-1:0]       OUT,
    output logic [CHANNELS-1:0]       BUSY,
    output logic [CHANNELS-1:0]       BERR
);

    if (SYNC_STAGES < 2 || TIMEOUT < 1) begin : g_bad_param
        $error("dtack_delay_sync: SYNC_STAGES must be >= 2 and TIMEOUT >= 1");
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        logic [2:0] chan_state;

        dtack_delay_chan #(
            .CNT_W       (CNT_W),
            .SYNC_STAGES (SYNC_STAGES)
`ifdef DTACK_TIMEOUT_EN
            ,
            .TIMEOUT     (TIMEOUT)
`endif
        ) u_chan (
            .clk     (CLK),
            .rst     (RESET),
            .as_n    (AS[g]),
            .dtack_n (DTACK[g]),
            .delay   (DELAY[g*CNT_W +: CNT_W]),
            .bypass  (BYPASS[g]),
            .out_n   (OUT[g]),
            .berr_n  (BERR[g]),
            .state_o (chan_state)
        );

        assign BUSY[g] = (chan_state != ST_IDLE);
    end

endmodule
